// File: rtl/bonk_pkg.sv
// bonk_pkg: shared FSM states, poll command, reply bit positions and hex glyphs for the bongo reader.
package bonk_pkg;
   typedef enum logic [2:0] {IDLE, TX, RX_WAIT, RX, UPDATE} state_t;
   localparam logic [23:0] POLL_CMD = 24'h400300;
   localparam logic [4:0] TX_LAST = 5'd24;
   // reply bit numbers in arrival order (0 = first bit on the wire)
   localparam logic [6:0] D0_LO = 7'd4;
   localparam logic [6:0] D0_HI = 7'd7;
   localparam logic [6:0] CHK_BIT = 7'd15;
   localparam logic [6:0] D1_LO = 7'd56;
   localparam logic [6:0] D1_HI = 7'd59;
   localparam logic [6:0] RX_BITS = 7'd64;
   localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   function automatic logic [6:0] glyph(input logic [3:0] d);
      return GLYPH[d];
   endfunction
endpackage

// File: rtl/clk_div_tick.sv
// clk_div_tick: one-cycle enable every DIV clock cycles.
module clk_div_tick #(
   parameter int DIV = 50
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int W = $clog2(DIV + 1);
   logic [W-1:0] cnt;
   assign tick = cnt == W'(DIV - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/bonk_pad_reader.sv
// bonk_pad_reader: polls DK Bongos over joybus and shows two reply nibbles on 7-segment displays.
// BONK_ERR_DP_EN defined lights seg0's decimal point while err is set.
module bonk_pad_reader
   import bonk_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int POLL_HZ = 100,
   parameter int RX_TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       rst,
   inout  logic       data_io,
   output logic [3:0] dig0,
   output logic [3:0] dig1,
   output logic [7:0] seg0,
   output logic [7:0] seg1,
   output logic       valid,
   output logic       err
);
   localparam int US = CLK_HZ / 1_000_000;
   localparam int CW = $clog2(RX_TIMEOUT * US + 1);
   localparam logic [CW-1:0] SAMP_C = CW'(2 * US - 1);
   localparam logic [CW-1:0] GAP_C = CW'(5 * US - 1);
   localparam logic [CW-1:0] TO_C = CW'(RX_TIMEOUT * US - 1);
   state_t state, nxt;
   logic us, poll, drv, fall, line, samp, abort, chk;
   logic [2:0] s;
   logic [1:0] sub;
   logic [4:0] bidx;
   logic [24:0] txsr;
   logic [CW-1:0] cnt;
   logic [6:0] rbits;
   logic [3:0] d0n, d1n;
   clk_div_tick #(.DIV(US)) u_us (.clk(clk), .rst(rst), .tick(us));
   clk_div_tick #(.DIV(CLK_HZ / POLL_HZ)) u_poll (.clk(clk), .rst(rst), .tick(poll));
   assign line = s[1];
   assign fall = s[2] & ~s[1];
   assign samp = !fall && cnt == SAMP_C;
   assign drv = state == TX && sub < (txsr[24] ? 2'd1 : 2'd3);
   assign data_io = drv ? 1'b0 : 1'bz;
   assign seg1 = {1'b1, glyph(dig1)};
`ifdef BONK_ERR_DP_EN
   assign seg0 = {~err, glyph(dig0)};
`else
   assign seg0 = {1'b1, glyph(dig0)};
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      abort = 1'b0;
      case (state)
         IDLE:    if (poll) nxt = TX;
         TX:      if (us && sub == 2'd3 && bidx == TX_LAST) nxt = RX_WAIT;
         RX_WAIT: if (fall) nxt = RX; else if (cnt == TO_C) abort = 1'b1;
         RX:      if (samp && rbits == RX_BITS) nxt = UPDATE; else if (!fall && cnt == GAP_C) abort = 1'b1;
         default: nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s <= 3'b111;
         sub <= '0;
         bidx <= '0;
         txsr <= '0;
         cnt <= '0;
         rbits <= '0;
         d0n <= '0;
         d1n <= '0;
         chk <= 1'b0;
      end else begin
         s <= {s[1:0], data_io};
         cnt <= (state == RX_WAIT || state == RX) && !fall ? cnt + 1'b1 : '0;
         if (state == IDLE) begin
            sub <= '0;
            bidx <= '0;
            txsr <= {POLL_CMD, 1'b1};
            rbits <= '0;
         end
         if (state == TX && us) begin
            sub <= sub + 1'b1;
            if (sub == 2'd3) begin
               bidx <= bidx + 1'b1;
               txsr <= {txsr[23:0], 1'b0};
            end
         end
         if (state == RX && samp && rbits != RX_BITS) begin
            rbits <= rbits + 1'b1;
            if (rbits >= D0_LO && rbits <= D0_HI) d0n <= {d0n[2:0], line};
            if (rbits == CHK_BIT) chk <= line;
            if (rbits >= D1_LO && rbits <= D1_HI) d1n <= {d1n[2:0], line};
         end
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         dig0 <= '0;
         dig1 <= '0;
         valid <= 1'b0;
         err <= 1'b0;
      end else begin
         valid <= state == UPDATE && chk;
         if (state == UPDATE && chk) begin
            dig0 <= d0n;
            dig1 <= d1n;
            err <= 1'b0;
         end else if (abort || state == UPDATE) err <= 1'b1;
      end
endmodule

// File: tb/tb_bonk_pad_reader.sv
// tb_bonk_pad_reader: joybus device model plus reply-level reference model for bonk_pad_reader.
module tb_bonk_pad_reader;
   localparam int US = 4;
   localparam int PD = 2000;
   localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`ifdef BONK_ERR_DP_EN
   localparam bit DP_EN = 1'b1;
`else
   localparam bit DP_EN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, dev_low = 1'b0;
   wire data_line;
   logic [3:0] dig0, dig1;
   logic [7:0] seg0, seg1;
   logic valid, err;
   int checks = 0, errors = 0, vcount = 0, exp_v = 0;
   longint cyc = 0, last_v = 0, prev_v = 0;
   bit hold = 1'b0, chk_en = 1'b0;
   logic [3:0] exp_dig0 = 4'h0, exp_dig1 = 4'h0;
   logic exp_err = 1'b0;
   assign data_line = dev_low ? 1'b0 : 1'bz;
   pullup (data_line);
   always #125 clk = ~clk;
   bonk_pad_reader #(.CLK_HZ(4_000_000), .POLL_HZ(2000), .RX_TIMEOUT(200)) dut (
      .clk(clk), .rst(rst), .data_io(data_line), .dig0(dig0), .dig1(dig1),
      .seg0(seg0), .seg1(seg1), .valid(valid), .err(err)
   );
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask
   function automatic logic [7:0] seg_of(input logic [3:0] d, input logic dp);
      logic [7:0] g;
      g = HEX[d];
      return {dp, g[6:0]};
   endfunction
   // outputs must match the model whenever no update window is open
   always @(negedge clk) begin
      cyc++;
      if (!rst && chk_en) begin
         if (valid) begin
            vcount++;
            prev_v = last_v;
            last_v = cyc;
         end
         if (!hold)
            check("outputs {dig0,dig1,seg0,seg1,err}", {dig0, dig1, seg0, seg1, err},
                  {exp_dig0, exp_dig1, seg_of(exp_dig0, DP_EN ? ~exp_err : 1'b1), seg_of(exp_dig1, 1'b1), exp_err});
      end
   end
   task automatic send_cell(input logic b);
      dev_low = 1'b1;
      repeat (b ? US : 3 * US) @(negedge clk);
      dev_low = 1'b0;
      repeat (b ? 3 * US : US) @(negedge clk);
   endtask
   // kind 0: full reply, 1: silent device, 2: reply cut after 30 bits
   task automatic run_poll(input int kind, input logic [63:0] r, input int gap, input bit first);
      int lo [25];
      int n, h, total;
      logic [24:0] cmd;
      cmd = {24'h400300, 1'b1};
      n = 0;
      while (data_line !== 1'b0 && n < 2 * PD) begin
         @(negedge clk);
         n++;
      end
      check("tx_start_seen", n < 2 * PD, 1);
      total = 0;
      for (int c = 0; c < 25; c++) begin
         n = 0;
         while (data_line === 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         h = 0;
         while (data_line !== 1'b0 && h < (c == 24 ? 3 * US : 20)) begin
            @(negedge clk);
            h++;
         end
         lo[c] = n;
         total += n + h;
         check("tx_cell_low_cycles", n, cmd[24-c] ? US : 3 * US);
      end
      check("tx_total_cycles", total, 100 * US);
      if (first) begin
         check("cell1_low_3us", lo[0], 12);
         check("cell2_low_1us", lo[1], 4);
      end
      if (kind == 1) begin
         repeat (199 * US) @(negedge clk);
         hold = 1'b1;
         repeat (4 * US) @(negedge clk);
         exp_err = 1'b1;
         hold = 1'b0;
      end else begin
         repeat (gap * US) @(negedge clk);
         for (int i = 0; i < (kind == 2 ? 30 : 64); i++) send_cell(r[63-i]);
         hold = 1'b1;
         if (kind == 0) begin
            send_cell(1'b1);
            repeat (US) @(negedge clk);
            if (r[48]) begin
               exp_dig0 = r[59:56];
               exp_dig1 = r[7:4];
               exp_err = 1'b0;
               exp_v++;
            end else exp_err = 1'b1;
         end else begin
            repeat (4 * US) @(negedge clk);
            exp_err = 1'b1;
         end
         hold = 1'b0;
      end
      check("valid_pulse_count", vcount, exp_v);
   endtask
   initial begin
      logic [63:0] r;
      int n;
      #10 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dig0", dig0, 4'h0);
      check("rst_dig1", dig1, 4'h0);
      check("rst_seg0", seg0, 8'hC0);
      check("rst_seg1", seg1, 8'hC0);
      check("rst_valid", valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_line_released", data_line, 1'b1);
      rst = 1'b0;
      chk_en = 1'b1;
      run_poll(0, 64'h0901_8080_8080_00F0, 5, 1'b1);
      check("good_dig0", dig0, 4'h9);
      check("good_dig1", dig1, 4'hF);
      check("good_seg0", seg0, 8'h90);
      check("good_seg1", seg1, 8'h8E);
      check("good_err", err, 1'b0);
      check("good_valid_once", vcount, 1);
      run_poll(1, 64'h0, 0, 1'b0);
      check("silent_err", err, 1'b1);
      check("silent_dig0_held", dig0, 4'h9);
      r = {$urandom, $urandom};
      r[48] = 1'b1;
      run_poll(0, r, $urandom_range(2, 20), 1'b0);
      run_poll(2, {$urandom, $urandom}, $urandom_range(2, 20), 1'b0);
      check("trunc_err", err, 1'b1);
      r = {$urandom, $urandom};
      r[48] = 1'b1;
      run_poll(0, r, $urandom_range(2, 20), 1'b0);
      check("next_good_clears_err", err, 1'b0);
      r = {$urandom, $urandom};
      r[48] = 1'b0;
      run_poll(0, r, $urandom_range(2, 20), 1'b0);
      check("discard_err", err, 1'b1);
      for (int i = 0; i < 4; i++) begin
         r = {$urandom, $urandom};
         r[59:56] = 4'b1010;
         r[48] = 1'b1;
         run_poll(0, r, 5, 1'b0);
         check("hit_dig0", dig0, 4'hA);
         if (i > 0) check("hit_valid_period", last_v - prev_v, PD);
      end
      for (int i = 0; i < 4; i++)
         run_poll($urandom_range(0, 2), {$urandom, $urandom}, $urandom_range(2, 20), 1'b0);
      n = 0;
      while (data_line !== 1'b0 && n < 2 * PD) begin
         @(negedge clk);
         n++;
      end
      check("rst_tx_seen", n < 2 * PD, 1);
      repeat (8) @(negedge clk);
      check("pre_rst_line_low", data_line, 1'b0);
      chk_en = 1'b0;
      #30 rst = 1'b1;
      #1;
      check("midtx_rst_line", data_line, 1'b1);
      check("midtx_rst_dig0", dig0, 4'h0);
      check("midtx_rst_dig1", dig1, 4'h0);
      check("midtx_rst_seg0", seg0, 8'hC0);
      check("midtx_rst_seg1", seg1, 8'hC0);
      check("midtx_rst_err", err, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
